// File: rtl/poly1305_pkg.sv
// Shared definitions for the poly1305 message sequencer.
//   BLOCK_BYTES : bytes per poly1305 block
//   CLAMP_MASK  : mask applied to the r half of the one-time key
//   state_t     : sequencer FSM states
//   clamp_r     : applies CLAMP_MASK to a 128-bit r value
package poly1305_pkg;

  localparam int BLOCK_BYTES = 16;

  localparam logic [127:0] CLAMP_MASK = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT,
    TAG
  } state_t;

  function automatic logic [127:0] clamp_r(input logic [127:0] r);
    return r & CLAMP_MASK;
  endfunction

endpackage

// File: rtl/poly1305_blkbuf.sv
// 16-byte little-endian block packing buffer with byte counter.
// The final byte of a message also drops the 0x01 pad marker into the
// following byte position, so the registered block is already padded
// by the time the sequencer issues it.
// Ports:
//   clk      : clock, rising edge
//   i_reset  : synchronous active-high reset
//   i_clr    : clear buffer and counter (new block)
//   i_wr     : accept i_data at position o_cnt
//   i_data   : message byte
//   i_last   : i_data is the final message byte (insert pad)
//   o_block  : packed block, byte 0 at [7:0]
//   o_full   : all 16 bytes present
//   o_cnt    : number of bytes written (0..16)
module poly1305_blkbuf
  import poly1305_pkg::*;
(
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_wr,
  input  logic [7:0]   i_data,
  input  logic         i_last,
  output logic [127:0] o_block,
  output logic         o_full,
  output logic [4:0]   o_cnt
);

  logic [7:0] r_byte [BLOCK_BYTES];
  logic [4:0] r_cnt;
  logic [4:0] w_pad_idx;

  // Pad position; equals 16 for a full final block, which matches no byte
  // lane, so a full final block gets no marker.
  assign w_pad_idx = r_cnt + 5'd1;

  always_ff @(posedge clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_wr) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
      always_ff @(posedge clk) begin
        if (i_reset || i_clr) begin
          r_byte[gi] <= 8'h00;
        end else if (i_wr && (r_cnt == 5'(gi))) begin
          r_byte[gi] <= i_data;
        end else if (i_wr && i_last && (w_pad_idx == 5'(gi))) begin
          r_byte[gi] <= 8'h01;
        end
      end
      assign o_block[8*gi +: 8] = r_byte[gi];
    end
  endgenerate

  assign o_full = (r_cnt == 5'(BLOCK_BYTES));
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/poly1305_ctrl.sv
// Message sequencer for a serial poly1305 core.
// Accepts a 256-bit one-time key and a byte stream, packs bytes into
// padded 16-byte blocks, strobes them into the core and returns the tag.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   key/key_valid/key_ready : key handshake (r = key[127:0], s = key[255:128])
//   in_data/in_last/in_valid/in_ready : message byte handshake
//   tag/tag_valid/tag_ready : tag output handshake
//   core_r, core_s        : clamped r and s to the core
//   core_m, core_fb, core_first, core_ld : block, full-block flag,
//                           first-block flag and one-cycle load strobe
//   core_p, core_rdy      : core result and done
module poly1305_ctrl
  import poly1305_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] tag,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic [127:0] core_r,
  output logic [127:0] core_s,
  output logic [127:0] core_m,
  output logic         core_fb,
  output logic         core_first,
  output logic         core_ld,
  input  logic [127:0] core_p,
  input  logic         core_rdy
);

  state_t       r_state;
  logic [127:0] r_core_r;
  logic [127:0] r_core_s;
  logic         r_core_fb;
  logic         r_core_first;
  logic         r_core_ld;
  logic [127:0] r_tag;
  logic         r_tag_valid;
  logic         r_first_pend;
  logic         r_last_pend;

  logic         w_key_acc;
  logic         w_wr;
  logic         w_blk_end;
  logic         w_done;
  logic         w_clr;
  logic         w_full;
  logic [4:0]   w_cnt;

  assign w_key_acc = (r_state == IDLE) && key_valid;
  // The full guard never fires in practice (a full block leaves FILL), but
  // it keeps the counter from ever wrapping into byte lane 0.
  assign w_wr      = (r_state == FILL) && in_valid && !w_full;
  assign w_blk_end = w_wr && (in_last || (w_cnt == 5'(BLOCK_BYTES - 1)));
  // core_rdy only counts in WAIT; a core still showing done from the
  // previous block during ISSUE must not complete the new one.
  assign w_done    = (r_state == WAIT) && core_rdy;
  assign w_clr     = w_key_acc || (w_done && !r_last_pend);

  // The packed buffer itself drives core_m; it is frozen from ISSUE until
  // completion because no bytes are accepted outside FILL.
  poly1305_blkbuf u_blkbuf (
    .clk     (clk),
    .i_reset (reset),
    .i_clr   (w_clr),
    .i_wr    (w_wr),
    .i_data  (in_data),
    .i_last  (in_last),
    .o_block (core_m),
    .o_full  (w_full),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_core_r     <= '0;
      r_core_s     <= '0;
      r_core_fb    <= 1'b0;
      r_core_first <= 1'b0;
      r_core_ld    <= 1'b0;
      r_tag        <= '0;
      r_tag_valid  <= 1'b0;
      r_first_pend <= 1'b0;
      r_last_pend  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_valid) begin
            r_core_r     <= clamp_r(key[127:0]);
            r_core_s     <= key[255:128];
            r_first_pend <= 1'b1;
            r_state      <= FILL;
          end
        end
        FILL: begin
          if (w_blk_end) begin
            r_last_pend  <= in_last;
            // Only a block that reached 16 bytes carries the 2^128 bit;
            // a short final block has its marker inside core_m instead.
            r_core_fb    <= (w_cnt == 5'(BLOCK_BYTES - 1));
            r_core_first <= r_first_pend;
            r_core_ld    <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_core_ld    <= 1'b0;
          r_first_pend <= 1'b0;
          r_state      <= WAIT;
        end
        WAIT: begin
          if (core_rdy) begin
            if (r_last_pend) begin
              r_tag       <= core_p;
              r_tag_valid <= 1'b1;
              r_state     <= TAG;
            end else begin
              r_state <= FILL;
            end
          end
        end
        TAG: begin
          if (tag_ready) begin
            r_tag_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign key_ready  = (r_state == IDLE);
  assign in_ready   = (r_state == FILL);
  assign core_r     = r_core_r;
  assign core_s     = r_core_s;
  assign core_fb    = r_core_fb;
  assign core_first = r_core_first;
  assign core_ld    = r_core_ld;
  assign tag        = r_tag;
  assign tag_valid  = r_tag_valid;

endmodule

// File: tb/tb_poly1305_ctrl.sv
`timescale 1ns/1ps
module tb_poly1305_ctrl;

  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [263:0] P130  = (264'd1 << 130) - 264'd5;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key;
  logic         key_valid;
  logic         key_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] tag;
  logic         tag_valid;
  logic         tag_ready;
  logic [127:0] core_r;
  logic [127:0] core_s;
  logic [127:0] core_m;
  logic         core_fb;
  logic         core_first;
  logic         core_ld;
  logic [127:0] core_p;
  logic         core_rdy;

  always #5 clk = ~clk;

  poly1305_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tag        (tag),
    .tag_valid  (tag_valid),
    .tag_ready  (tag_ready),
    .core_r     (core_r),
    .core_s     (core_s),
    .core_m     (core_m),
    .core_fb    (core_fb),
    .core_first (core_first),
    .core_ld    (core_ld),
    .core_p     (core_p),
    .core_rdy   (core_rdy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural serial core ----------------
  // Done is a level: high while idle, low for a random latency after a load.
  function automatic logic [263:0] core_step(input logic [263:0] acc, input logic [127:0] m,
                                             input logic fb, input logic first, input logic [127:0] r);
    logic [263:0] a;
    a = first ? 264'd0 : acc;
    a = a + {136'd0, m} + (fb ? (264'd1 << 128) : 264'd0);
    return (a * {136'd0, r}) % P130;
  endfunction

  function automatic logic [127:0] add_s(input logic [263:0] acc, input logic [127:0] s);
    logic [263:0] a;
    a = acc + {136'd0, s};
    return a[127:0];
  endfunction

  logic [263:0] mdl_acc;
  logic [127:0] mdl_pn;
  int           mdl_lat;
  logic         mdl_busy;

  always @(posedge clk) begin
    if (reset) begin
      mdl_acc  <= '0;
      mdl_pn   <= '0;
      mdl_lat  <= 0;
      mdl_busy <= 1'b0;
      core_rdy <= 1'b1;
      core_p   <= '0;
    end else if (core_ld) begin
      mdl_acc  <= core_step(mdl_acc, core_m, core_fb, core_first, core_r);
      mdl_pn   <= add_s(core_step(mdl_acc, core_m, core_fb, core_first, core_r), core_s);
      mdl_lat  <= $urandom_range(2, 6);
      mdl_busy <= 1'b1;
      core_rdy <= 1'b0;
    end else if (mdl_busy) begin
      if (mdl_lat <= 1) begin
        core_rdy <= 1'b1;
        core_p   <= mdl_pn;
        mdl_busy <= 1'b0;
      end else begin
        mdl_lat <= mdl_lat - 1;
      end
    end
  end

  // ---------------- reference model over the whole message ----------------
  logic [7:0] msg_q[$];

  function automatic logic [127:0] ref_tag(input logic [255:0] k);
    logic [263:0] acc, r, blk;
    int n;
    r   = {136'd0, k[127:0] & CLAMP};
    acc = '0;
    for (int i = 0; i < msg_q.size(); i += 16) begin
      n = msg_q.size() - i;
      if (n > 16) n = 16;
      blk = '0;
      for (int j = 0; j < n; j++) blk[8*j +: 8] = msg_q[i+j];
      blk = blk | (264'd1 << (8*n));
      acc = ((acc + blk) * r) % P130;
    end
    return add_s(acc, k[255:128]);
  endfunction

  // {fb, m} expected for block b
  function automatic logic [128:0] ref_block(input int b);
    logic [127:0] m;
    int n;
    n = msg_q.size() - 16*b;
    if (n > 16) n = 16;
    m = '0;
    for (int j = 0; j < n; j++) m[8*j +: 8] = msg_q[16*b + j];
    if (n < 16) m[8*n +: 8] = 8'h01;
    return {(n == 16), m};
  endfunction

  function automatic logic [255:0] le256(input logic [255:0] be);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = be[255 - 8*i -: 8];
    return v;
  endfunction

  function automatic logic [127:0] le128(input logic [127:0] be);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = be[127 - 8*i -: 8];
    return v;
  endfunction

  // ---------------- monitor ----------------
  logic [127:0] ld_m_q[$];
  logic         ld_fb_q[$];
  logic         ld_first_q[$];
  int           n_acc = 0;
  logic         prev_tv;
  logic [127:0] prev_tag;

  always @(negedge clk) begin
    if (reset) begin
      prev_tv  <= 1'b0;
      prev_tag <= '0;
    end else begin
      if (core_ld) begin
        ld_m_q.push_back(core_m);
        ld_fb_q.push_back(core_fb);
        ld_first_q.push_back(core_first);
      end
      if (in_valid && in_ready) n_acc <= n_acc + 1;
      if (tag_valid && prev_tv) check("tag_stable", tag, prev_tag);
      if (tag_valid || mdl_busy || core_ld) begin
        check("busy_in_ready", in_ready, 1'b0);
        check("busy_key_ready", key_ready, 1'b0);
      end
      prev_tv  <= tag_valid;
      prev_tag <= tag;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic reset_check(input string nm);
    check({nm, "/key_ready"}, key_ready, 1'b1);
    check({nm, "/in_ready"}, in_ready, 1'b0);
    check({nm, "/tag_valid"}, tag_valid, 1'b0);
    check({nm, "/tag"}, tag, 128'd0);
    check({nm, "/core_ld"}, core_ld, 1'b0);
    check({nm, "/core_first"}, core_first, 1'b0);
    check({nm, "/core_fb"}, core_fb, 1'b0);
    check({nm, "/core_m"}, core_m, 128'd0);
    check({nm, "/core_r"}, core_r, 128'd0);
    check({nm, "/core_s"}, core_s, 128'd0);
  endtask

  task automatic send_key(input logic [255:0] k);
    int w = 0;
    key       = k;
    key_valid = 1'b1;
    while (!key_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("key_wait", key_ready, 1'b1);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit gap);
    int w;
    for (int i = lo; i <= hi; i++) begin
      if (gap && i != lo) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_data  = msg_q[i];
      in_last  = (i == msg_q.size() - 1);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      check("in_wait", in_ready, 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // hold == 0: tag_ready is raised before the tag appears
  task automatic get_tag(input int hold, output logic [127:0] t);
    int w = 0;
    if (hold == 0) tag_ready = 1'b1;
    while (!tag_valid && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("tag_wait", tag_valid, 1'b1);
    t = tag;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("tag_held", tag_valid, 1'b1);
    end
    tag_ready = 1'b1;
    @(negedge clk);
    check("tag_drop", tag_valid, 1'b0);
    tag_ready = 1'b0;
  endtask

  task automatic run_msg(input string nm, input logic [255:0] k, input bit gap,
                         input int hold, output logic [127:0] t);
    int n0, nb;
    logic [128:0] e;
    ld_m_q.delete();
    ld_fb_q.delete();
    ld_first_q.delete();
    n0 = n_acc;
    send_key(k);
    check({nm, "/core_r"}, core_r, k[127:0] & CLAMP);
    check({nm, "/core_s"}, core_s, k[255:128]);
    send_range(0, msg_q.size() - 1, gap);
    get_tag(hold, t);
    nb = (msg_q.size() + 15) / 16;
    check({nm, "/bytes"}, n_acc - n0, msg_q.size());
    check({nm, "/loads"}, ld_m_q.size(), nb);
    for (int b = 0; b < nb && b < ld_m_q.size(); b++) begin
      e = ref_block(b);
      check({nm, "/m"}, ld_m_q[b], e[127:0]);
      check({nm, "/fb"}, ld_fb_q[b], e[128]);
      check({nm, "/first"}, ld_first_q[b], (b == 0));
    end
    check({nm, "/tag"}, t, ref_tag(k));
    $display("msg %s len=%0d loads=%0d tag=%032h", nm, msg_q.size(), ld_m_q.size(), t);
  endtask

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  // ---------------- main sequence ----------------
  logic [255:0] rfc_key;
  logic [127:0] rfc_tag;
  logic [127:0] t;
  logic [127:0] blk2;
  logic [255:0] k;
  int           lens[7];

  initial begin
    reset     = 1'b1;
    key       = '0;
    key_valid = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    tag_ready = 1'b0;
    rfc_key = le256(256'h85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b);
    rfc_tag = le128(128'ha8061dc1305136c6c22b8baf0c0127a9);

    // reset with key_valid asserted: key must be ignored
    key       = rfc_key;
    key_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_check("rst");
    key_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);

    // RFC 8439 vector
    load_str("Cryptographic Forum Research Group");
    run_msg("rfc", rfc_key, 1'b0, 2, t);
    check("rfc/tag_const", t, rfc_tag);
    if (ld_m_q.size() >= 3) begin
      blk2 = ld_m_q[2];
      check("rfc/pad_byte", blk2[23:16], 8'h01);
    end

    // exact 32-byte message, r = 0, s = 00..0f
    msg_q.delete();
    for (int i = 0; i < 32; i++) msg_q.push_back(8'($urandom));
    k = '0;
    for (int i = 0; i < 16; i++) k[128 + 8*i +: 8] = 8'(i);
    run_msg("exact32", k, 1'b0, 1, t);
    check("exact32/tag_const", t, 128'h0f0e0d0c0b0a09080706050403020100);

    // single zero byte, zero key
    msg_q.delete();
    msg_q.push_back(8'h00);
    run_msg("one", 256'd0, 1'b0, 1, t);
    check("one/m_const", (ld_m_q.size() > 0) ? ld_m_q[0] : 128'hx, 128'h100);
    check("one/tag_const", t, 128'd0);

    // backpressure: gapped input, tag held off for 10 cycles
    load_str("Cryptographic Forum Research Group");
    run_msg("bp", rfc_key, 1'b1, 10, t);
    check("bp/tag_const", t, rfc_tag);

    // reset during WAIT of block 2, then rerun
    ld_m_q.delete();
    send_key(rfc_key);
    send_range(0, 31, 1'b0);
    @(negedge clk);
    check("rstmid/in_wait", mdl_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset_check("rstmid");
    reset = 1'b0;
    @(negedge clk);
    run_msg("rerun", rfc_key, 1'b0, 1, t);
    check("rerun/tag_const", t, rfc_tag);

    // back-to-back, tag_ready held high in advance
    run_msg("b2b1", rfc_key, 1'b0, 0, t);
    check("b2b1/tag_const", t, rfc_tag);
    run_msg("b2b2", rfc_key, 1'b0, 0, t);
    check("b2b2/tag_const", t, rfc_tag);

    // random messages around block boundaries
    lens[0] = 15; lens[1] = 16; lens[2] = 17; lens[3] = 48;
    lens[4] = $urandom_range(1, 60);
    lens[5] = $urandom_range(1, 60);
    lens[6] = $urandom_range(1, 60);
    for (int n = 0; n < 7; n++) begin
      msg_q.delete();
      for (int i = 0; i < lens[n]; i++) msg_q.push_back(8'($urandom));
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
      run_msg("rand", k, 1'($urandom_range(0, 1)), $urandom_range(0, 4), t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly1305_ctrl.md
# poly1305_ctrl

Message sequencer for the serial `poly1305` core. It accepts a 256-bit one-time key and a byte-serial message with AXI-style valid/ready handshakes. It packs bytes into 16-byte little-endian blocks, applies final-block padding, and pulses the core's `ld`/`first`/`fb` controls. When the core signals done on the last block, it presents the 128-bit tag on an output handshake. It sits between the system stream interface and the core.

## Interface
- No parameters. Block size is fixed at 16 bytes; key width is fixed at 256 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `key` in 256: bytes 0..15 in `key[127:0]` (r); bytes 16..31 in `key[255:128]` (s). Byte 0 sits at bits [7:0].
- `key_valid` in 1, `key_ready` out 1: key handshake, accepted in IDLE only.
- `in_data` in 8: message byte.
- `in_last` in 1: marks the final message byte. Every message is at least 1 byte long.
- `in_valid` in 1, `in_ready` out 1: byte handshake.
- `tag` out 128: little-endian tag, tag byte 0 at [7:0].
- `tag_valid` out 1, `tag_ready` in 1: tag handshake.
- `core_r` out 128, `core_s` out 128: to core `r`, `s`.
- `core_m` out 128, `core_fb` out 1, `core_first` out 1: to core `m`, `fb`, `first`.
- `core_ld` out 1: one-cycle load strobe.
- `core_p` in 128, `core_rdy` in 1: core result and done.

## Operation
- **States:** IDLE → FILL → ISSUE → WAIT → (FILL | TAG) → IDLE.
- **IDLE**
  - `key_ready=1`.
  - On `key_valid`, latch `core_r = key[127:0] & 128'h0ffffffc0ffffffc0ffffffc0fffffff` (clamp; it is idempotent, so core-side clamping is harmless).
  - Latch `core_s = key[255:128]`, set `first_pend=1`, clear the block buffer and `cnt`, then go to FILL.
- **FILL**
  - `in_ready=1`.
  - Each accepted byte is written to buffer bits `[8*cnt+7:8*cnt]`, and `cnt` (5 bits, 0..16) increments.
  - On the 16th byte, or any byte with `in_last`, go to ISSUE and record `last_pend=in_last`.
- **Padding (final block only)**
  - If `cnt<16` after the final byte: byte `cnt` = 0x01, bytes above it = 0, `core_fb=0`.
  - If `cnt==16`: no padding, `core_fb=1`.
  - A message whose length is a multiple of 16 issues no extra padding block.
- **ISSUE**
  - Drive `core_m` = buffer, `core_first=first_pend`, `core_fb`, and `core_ld=1` for exactly one cycle.
  - Clear `first_pend`, then go to WAIT.
- **WAIT**
  - `core_ld=0`. `core_m`, `core_fb` and `core_first` hold stable until done.
  - `core_rdy` is ignored in the ISSUE cycle.
  - The first cycle in WAIT with `core_rdy=1` is completion:
    - if `last_pend=0`: clear the buffer and `cnt`, go to FILL;
    - otherwise: latch `tag=core_p`, go to TAG.
- **TAG**
  - `tag_valid=1`; `tag` holds stable while `tag_ready=0`.
  - On `tag_ready`, drop `tag_valid` and go to IDLE.
- **Backpressure**
  - `in_ready=0` in every state except FILL.
  - `key_ready=0` in every state except IDLE.
  - Input bytes are never dropped or duplicated.
- **Reset:** reset in any state, including mid-block or WAIT, returns to IDLE next cycle. The partial message is discarded and no tag is produced.

## Timing
- **Reset values**
  - State = IDLE, so `key_ready=1` in the first cycle after reset.
  - `in_ready=0`, `tag_valid=0`, `tag=0`, `core_ld=0`, `core_first=0`, `core_fb=0`.
  - `core_m=0`, `core_r=0`, `core_s=0`, `cnt=0`.
- **Throughput:** one byte per cycle in FILL.
- **Issue latency:** `core_ld` is high in the cycle after the block's final byte is accepted.
- **Next block:** FILL resumes the cycle after completion is seen. Block overhead is 2 cycles plus core latency.
- **Tag latency:** `tag_valid` rises the cycle after the last block's `core_rdy`.
- **Simultaneous events:**
  - `key_valid` together with `reset`: the key is ignored.
  - `tag_ready` held high in advance: `tag_valid` lasts exactly 1 cycle.
- **Control outputs:** `core_*` and `tag` are registered. `in_ready` and `key_ready` decode combinationally from state.

## Structure
- Shared package `poly1305_pkg` holds:
  - `BLOCK_BYTES=16`;
  - the clamp mask constant;
  - the state enum {IDLE, FILL, ISSUE, WAIT, TAG}.
- One natural sub-module, `poly1305_blkbuf`: the 16-byte packing buffer with byte counter and pad insertion. It outputs `block[127:0]`, `full`, `cnt`.
- The FSM lives in `poly1305_ctrl`.
- Testbench top instantiates `poly1305_ctrl` plus the real `poly1305` core.

## Test plan
- **RFC 8439 §2.5.2 vector**
  - Stimulus: key `85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b`; message "Cryptographic Forum Research Group" (34 bytes).
  - Required response: 3 `core_ld` pulses; `core_first` = 1,0,0; `core_fb` = 1,1,0. The third block has `m[23:16]=8'h01`. `tag` bytes = `a8061dc1305136c6c22b8baf0c0127a9`.
- **Exact 32-byte message, r=0, s=`00..0f`**
  - Required response: 2 loads, both `fb=1`, no pad block. `tag` = s, i.e. `128'h0f0e..0100`.
- **1-byte message 0x00, all-zero key**
  - Required response: one load with `core_m=128'h100` and `fb=0`. `tag=0`.
- **Backpressure**
  - Stimulus: `in_valid` toggled every other cycle; `tag_ready` low for 10 cycles.
  - Required response: byte count and packing are unchanged. `tag_valid` stays high and `tag` stays stable throughout. `in_ready=0` and `key_ready=0` during WAIT and TAG.
- **Reset mid-operation**
  - Stimulus: reset asserted during WAIT of block 2, then the RFC vector is re-run.
  - Required response: IDLE next cycle with all outputs at reset values. The re-run yields the correct tag.
- **Back-to-back messages**
  - Stimulus: two RFC runs with no idle gap.
  - Required response: `core_first=1` on the first block of each message only; both tags are correct.
